// File: rtl/mem_io_responder.sv
// mem_io_responder: synchronous-read RAM plus a 16-word memory-mapped I/O
// window (TX FIFO, free-running cycle counter, sticky halt flag) sitting
// behind the projectCPU memory port.
module mem_io_responder #(
    parameter int unsigned       ADDR_W     = 13,
    parameter int unsigned       DATA_W     = 16,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 13'h1FF0,
    parameter int unsigned       FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_ram_data_in,
    output logic [DATA_W-1:0] o_ram_data_out,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_halt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [3:0] {
        REG_TXDATA = 4'd0,
        REG_STATUS = 4'd1,
        REG_CYCLES = 4'd2,
        REG_HALT   = 4'd3
    } mmioReg_e;

    // Storage
    logic [DATA_W-1:0] ram [0:MMIO_BASE-1];
    logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];

    // Control/status state
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  fifoCount;
    logic              overflow;
    logic              haltFlag;
    logic [15:0]       cycleCount;

    // Address decode
    logic [ADDR_W-1:0] mmioDelta;
    logic [3:0]        mmioOff;
    logic              ramSel;
    logic              mmioSel;

    // Write strobes and FIFO handshake
    logic              wrTx;
    logic              wrStatus;
    logic              wrCycles;
    logic              wrHalt;
    logic              fifoFull;
    logic              fifoPop;
    logic              fifoPush;

    logic [DATA_W-1:0] statusWord;
    logic [DATA_W-1:0] readNext;

    assign mmioDelta = i_addr - MMIO_BASE;
    assign mmioOff   = mmioDelta[3:0];
    assign ramSel    = (i_addr < MMIO_BASE);
    assign mmioSel   = !ramSel && (mmioDelta[ADDR_W-1:4] == '0);

    assign wrTx      = i_we && mmioSel && (mmioOff == REG_TXDATA);
    assign wrStatus  = i_we && mmioSel && (mmioOff == REG_STATUS);
    assign wrCycles  = i_we && mmioSel && (mmioOff == REG_CYCLES);
    assign wrHalt    = i_we && mmioSel && (mmioOff == REG_HALT);

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; only a push with no room and no pop is dropped.
    assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign fifoPop   = (fifoCount != '0) && i_tx_ready;
    assign fifoPush  = wrTx && (!fifoFull || fifoPop);

    assign o_tx_valid = (fifoCount != '0);
    assign o_tx_data  = o_tx_valid ? fifoMem[rdPtr] : '0;
    assign o_halt     = haltFlag;

    assign statusWord = {overflow, haltFlag, {(DATA_W-6){1'b0}}, 4'(fifoCount)};

    // Read mux: all sources are sampled before this edge's updates, which
    // gives read-first RAM and pre-update STATUS/CYCLES values.
    always_comb begin
        readNext = '0;
        if (ramSel) begin
            readNext = ram[i_addr];
        end else if (mmioSel) begin
            case (mmioOff)
                REG_STATUS: readNext = statusWord;
                REG_CYCLES: readNext = DATA_W'(cycleCount);
                REG_HALT:   readNext = {{(DATA_W-1){1'b0}}, haltFlag};
                default:    readNext = '0;
            endcase
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (i_we && ramSel) begin
            ram[i_addr] <= i_ram_data_in;
        end
    end

    // FIFO storage write; validity is tracked by the count, so no reset
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoMem[wrPtr] <= i_ram_data_in;
        end
    end

    // Registered read data, one cycle after the address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ram_data_out <= '0;
        end else begin
            o_ram_data_out <= readNext;
        end
    end

    // FIFO pointers/count, overflow and halt flags, cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifoCount  <= '0;
            overflow   <= 1'b0;
            haltFlag   <= 1'b0;
            cycleCount <= '0;
        end else begin
            if (fifoPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (fifoPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
            if (wrTx && fifoFull && !fifoPop) begin
                overflow <= 1'b1;
            end else if (wrStatus) begin
                overflow <= 1'b0;
            end
            if (wrHalt && (i_ram_data_in != '0)) begin
                haltFlag <= 1'b1;
            end
            cycleCount <= wrCycles ? '0 : cycleCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder. A queue-based FIFO model, an
// associative-array RAM model and edge arithmetic for the cycle counter
// supply every expected value.
module tb_mem_io_responder;

    localparam logic [12:0] BASE   = 13'h1FF0;
    localparam logic [12:0] TXDATA = BASE;
    localparam logic [12:0] STATUS = BASE + 13'd1;
    localparam logic [12:0] CYCLES = BASE + 13'd2;
    localparam logic [12:0] HALT   = BASE + 13'd3;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_we;
    logic [12:0] i_addr;
    logic [15:0] i_ram_data_in;
    logic [15:0] o_ram_data_out;
    logic        o_tx_valid;
    logic [15:0] o_tx_data;
    logic        i_tx_ready;
    logic        o_halt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] fifoQ[$];
    logic [15:0] ramModel[int];
    logic        modelOvf = 1'b0;
    logic        modelHalt = 1'b0;
    int          edgeNo = 0;
    int          clearEdge = 0;
    logic [15:0] expRead;

    mem_io_responder #(
        .ADDR_W(13),
        .DATA_W(16),
        .MMIO_BASE(13'h1FF0),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_we(i_we),
        .i_addr(i_addr),
        .i_ram_data_in(i_ram_data_in),
        .o_ram_data_out(o_ram_data_out),
        .o_tx_valid(o_tx_valid),
        .o_tx_data(o_tx_data),
        .i_tx_ready(i_tx_ready),
        .o_halt(o_halt)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Value a read of address a returns when sampled at the coming edge.
    // The counter was zero right after clearEdge and gains one per edge.
    function automatic logic [15:0] modelRead(input logic [12:0] a);
        if (a < BASE) begin
            return ramModel.exists(int'(a)) ? ramModel[int'(a)] : 16'h0000;
        end
        case (a - BASE)
            13'd1:   return {modelOvf, modelHalt, 10'b0, 4'(fifoQ.size())};
            13'd2:   return 16'(edgeNo - clearEdge);
            13'd3:   return {15'b0, modelHalt};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void modelReset();
        fifoQ.delete();
        modelOvf  = 1'b0;
        modelHalt = 1'b0;
        clearEdge = edgeNo;
    endfunction

    // Drive one bus cycle from a negedge, advance the model over the
    // rising edge, return at the next negedge for sampling.
    task automatic step(input logic we, input logic [12:0] addr,
                        input logic [15:0] data, input logic ready);
        logic popNow;
        i_we          = we;
        i_addr        = addr;
        i_ram_data_in = data;
        i_tx_ready    = ready;
        expRead = modelRead(addr);
        popNow  = ready && (fifoQ.size() != 0);
        @(posedge clk);
        edgeNo++;
        if (popNow) void'(fifoQ.pop_front());
        if (we && addr == TXDATA) begin
            if (fifoQ.size() < DEPTH) fifoQ.push_back(data);
            else modelOvf = 1'b1;
        end
        if (we && addr < BASE) ramModel[int'(addr)] = data;
        if (we && addr == STATUS) modelOvf = 1'b0;
        if (we && addr == CYCLES) clearEdge = edgeNo;
        if (we && addr == HALT && data != 16'h0) modelHalt = 1'b1;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_we = 1'b0; i_addr = '0; i_ram_data_in = '0; i_tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_ram_data_out !== 16'h0000 || o_tx_valid !== 1'b0 || o_tx_data !== 16'h0000 || o_halt !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%h v=%b d=%h h=%b expected 0000 0 0000 0",
                     o_ram_data_out, o_tx_valid, o_tx_data, o_halt);
        end
        rst = 1'b1;
        modelReset();
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_status: got %h expected 0000", o_ram_data_out);
        end
    endtask

    task automatic test_ram();
        step(1, 13'd200, 16'h1234, 0);
        step(0, 13'd200, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h1234) begin
            failures++;
            $display("FAIL ram_read: got %h expected 1234", o_ram_data_out);
        end
        step(0, BASE + 13'd5, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0000) begin
            failures++;
            $display("FAIL ram_latency: got %h expected 0000", o_ram_data_out);
        end
        step(1, 13'd201, 16'hAAAA, 0);
        step(1, 13'd201, 16'h5555, 0);
        checks++;
        if (o_ram_data_out !== 16'hAAAA) begin
            failures++;
            $display("FAIL ram_read_first: got %h expected aaaa", o_ram_data_out);
        end
        step(0, 13'd201, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h5555) begin
            failures++;
            $display("FAIL ram_after_write: got %h expected 5555", o_ram_data_out);
        end
    endtask

    task automatic test_fifo_order();
        checks++;
        if (o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL fifo_empty_start: got valid=%b expected 0", o_tx_valid);
        end
        step(1, TXDATA, 16'd1, 0);
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 16'd1) begin
            failures++;
            $display("FAIL fifo_first_push: got v=%b d=%h expected 1 0001", o_tx_valid, o_tx_data);
        end
        step(1, TXDATA, 16'd2, 0);
        step(1, TXDATA, 16'd3, 0);
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0003) begin
            failures++;
            $display("FAIL fifo_status3: got %h expected 0003", o_ram_data_out);
        end
        checks++;
        if (o_tx_data !== 16'd1) begin
            failures++;
            $display("FAIL fifo_hold: got %h expected 0001", o_tx_data);
        end
        for (int i = 2; i <= 3; i++) begin
            step(0, BASE + 13'd6, 16'h0, 1);
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== 16'(i)) begin
                failures++;
                $display("FAIL fifo_drain: got v=%b d=%h expected 1 %h", o_tx_valid, o_tx_data, 16'(i));
            end
        end
        step(0, STATUS, 16'h0, 1);
        checks++;
        if (o_tx_valid !== 1'b0 || o_ram_data_out !== 16'h0001) begin
            failures++;
            $display("FAIL fifo_drained: got v=%b status=%h expected 0 0001", o_tx_valid, o_ram_data_out);
        end
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0000) begin
            failures++;
            $display("FAIL fifo_status0: got %h expected 0000", o_ram_data_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) step(1, TXDATA, 16'(16'h0100 + i), 0);
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h8008) begin
            failures++;
            $display("FAIL ovf_status: got %h expected 8008", o_ram_data_out);
        end
        step(1, STATUS, 16'hFFFF, 0);
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0008) begin
            failures++;
            $display("FAIL ovf_clear: got %h expected 0008", o_ram_data_out);
        end
        step(1, TXDATA, 16'hBEEF, 1);
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0008) begin
            failures++;
            $display("FAIL ovf_push_pop_full: got %h expected 0008", o_ram_data_out);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] want;
            want = (i < 7) ? 16'(16'h0101 + i) : 16'hBEEF;
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== want) begin
                failures++;
                $display("FAIL ovf_order: got v=%b d=%h expected 1 %h", o_tx_valid, o_tx_data, want);
            end
            step(0, BASE + 13'd7, 16'h0, 1);
        end
        checks++;
        if (o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_empty: got valid=%b expected 0", o_tx_valid);
        end
    endtask

    task automatic test_counter();
        doReset();
        repeat (100) step(0, BASE + 13'd4, 16'h0, 0);
        step(0, CYCLES, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'd100) begin
            failures++;
            $display("FAIL cycles_100: got %0d expected 100", o_ram_data_out);
        end
        step(1, CYCLES, 16'h1234, 0);
        step(0, BASE + 13'd4, 16'h0, 0);
        step(0, CYCLES, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'd1) begin
            failures++;
            $display("FAIL cycles_clear: got %0d expected 1", o_ram_data_out);
        end
        step(1, CYCLES, 16'h0, 0);
        repeat (65535) step(0, BASE + 13'd4, 16'h0, 0);
        step(0, CYCLES, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'hFFFF) begin
            failures++;
            $display("FAIL cycles_max: got %h expected ffff", o_ram_data_out);
        end
        step(0, CYCLES, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0000) begin
            failures++;
            $display("FAIL cycles_wrap: got %h expected 0000", o_ram_data_out);
        end
    endtask

    task automatic test_halt();
        step(1, HALT, 16'h0000, 0);
        checks++;
        if (o_halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_zero: got %b expected 0", o_halt);
        end
        step(1, HALT, 16'h0007, 0);
        checks++;
        if (o_halt !== 1'b1) begin
            failures++;
            $display("FAIL halt_set: got %b expected 1", o_halt);
        end
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h4000) begin
            failures++;
            $display("FAIL halt_status: got %h expected 4000", o_ram_data_out);
        end
        step(1, HALT, 16'h0000, 0);
        step(0, HALT, 16'h0, 0);
        checks++;
        if (o_halt !== 1'b1 || o_ram_data_out !== 16'h0001) begin
            failures++;
            $display("FAIL halt_sticky: got h=%b rd=%h expected 1 0001", o_halt, o_ram_data_out);
        end
    endtask

    task automatic test_random();
        int unsigned op;
        logic        rdy;
        logic        we;
        logic [12:0] a;
        logic [15:0] d;
        for (int i = 0; i < 8; i++) step(1, 13'(300 + i), 16'($urandom), 0);
        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 7);
            rdy = ($urandom_range(0, 3) == 0);
            d   = 16'($urandom);
            we  = 1'b0;
            a   = BASE + 13'd4;
            case (op)
                0: begin we = 1'b1; a = 13'(300 + $urandom_range(0, 7)); end
                1: begin we = 1'b0; a = 13'(300 + $urandom_range(0, 7)); end
                2, 3: begin we = 1'b1; a = TXDATA; end
                4: begin we = 1'b0; a = STATUS; end
                5: begin we = 1'b0; a = CYCLES; end
                6: begin we = 1'($urandom_range(0, 1)); a = 13'(BASE + 13'd4 + 13'($urandom_range(0, 11))); end
                default: begin we = 1'b1; a = STATUS; end
            endcase
            step(we, a, d, rdy);
            checks++;
            if (o_ram_data_out !== expRead) begin
                failures++;
                $display("FAIL rand_read: addr=%h got %h expected %h", a, o_ram_data_out, expRead);
            end
            checks++;
            if (o_tx_valid !== (fifoQ.size() != 0)) begin
                failures++;
                $display("FAIL rand_valid: got %b expected %b", o_tx_valid, fifoQ.size() != 0);
            end
            if (fifoQ.size() != 0) begin
                checks++;
                if (o_tx_data !== fifoQ[0]) begin
                    failures++;
                    $display("FAIL rand_head: got %h expected %h", o_tx_data, fifoQ[0]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (10) step(0, BASE + 13'd4, 16'h0, 1);
        for (int i = 0; i < 5; i++) step(1, TXDATA, 16'(16'h0A00 + i), 0);
        step(0, BASE + 13'd4, 16'h0, 1);
        step(0, 13'd200, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h1234 || o_tx_valid !== 1'b1 || fifoQ.size() != 4) begin
            failures++;
            $display("FAIL arst_setup: got rd=%h v=%b q=%0d expected 1234 1 4",
                     o_ram_data_out, o_tx_valid, fifoQ.size());
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (o_tx_valid !== 1'b0 || o_ram_data_out !== 16'h0000 || o_tx_data !== 16'h0000 || o_halt !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: got v=%b rd=%h d=%h h=%b expected 0 0000 0000 0",
                     o_tx_valid, o_ram_data_out, o_tx_data, o_halt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        step(0, STATUS, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h0000 || o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_status: got %h v=%b expected 0000 0", o_ram_data_out, o_tx_valid);
        end
        step(0, 13'd200, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== 16'h1234) begin
            failures++;
            $display("FAIL arst_ram_kept: got %h expected 1234", o_ram_data_out);
        end
        step(0, CYCLES, 16'h0, 0);
        checks++;
        if (o_ram_data_out !== expRead || o_ram_data_out !== 16'd2) begin
            failures++;
            $display("FAIL arst_cycles: got %0d expected 2", o_ram_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_order();
        test_overflow();
        test_counter();
        test_halt();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the projectCPU memory interface. It replaces the plain block RAM with a 1-cycle synchronous-read RAM and a small memory-mapped I/O window at the top of the address space. The window holds a TX output FIFO with a valid/ready drain port, a free-running cycle counter, and a sticky halt flag. The CPU connects unchanged through its wrEn, addr_toRAM, data_toRAM and data_fromRAM ports.

Parameters:
ADDR_W, 13, address width; RAM covers 0 .. MMIO_BASE-1
DATA_W, 16, data width
MMIO_BASE, 13'h1FF0, first address of the I/O window (16 words)
FIFO_DEPTH, 8, TX FIFO entries; power of two, at most 8

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low
i_we  in  1  write enable from CPU (wrEn)
i_addr  in  ADDR_W  address from CPU (addr_toRAM)
i_ram_data_in  in  DATA_W  write data from CPU (data_toRAM)
o_ram_data_out  out  DATA_W  registered read data to CPU (data_fromRAM)
o_tx_valid  out  1  TX FIFO non-empty
o_tx_data  out  DATA_W  TX FIFO head word
i_tx_ready  in  1  consumer accepts head when high with o_tx_valid
o_halt  out  1  sticky halt request

Behaviour:
- Reset (rst=0, async): o_ram_data_out=0; FIFO empty, so o_tx_valid=0 and o_tx_data=0; cycle counter=0; o_halt=0; overflow flag=0. RAM contents are not cleared.
- Read latency is exactly 1 cycle. o_ram_data_out at edge N+1 reflects i_addr sampled at edge N. This holds for RAM and for MMIO.
- RAM, i_addr < MMIO_BASE:
  - A write with i_we=1 stores i_ram_data_in at the edge.
  - A same-cycle read and write to one address is read-first: the read returns the old value.
- MMIO, offset = i_addr - MMIO_BASE:
  - 0 TXDATA: a write pushes the word into the FIFO. A read returns 0.
  - 1 STATUS (read-only): [15] overflow, [14] halt, [13:4] 0, [3:0] FIFO count. A write clears overflow; halt is unaffected.
  - 2 CYCLES: a read returns the counter. A write makes the counter 0 on the next cycle, and it resumes counting after that.
  - 3 HALT: a write with non-zero data sets o_halt. A write of zero is ignored. A read returns {15'b0, halt}.
  - 4..15: reads return 0. Writes are ignored.
- Cycle counter:
  - Increments every cycle after reset deasserts.
  - 16-bit, wraps 0xFFFF -> 0x0000.
  - When a counter clear and a read occur in the same cycle, the read returns the pre-clear value.
- TX FIFO:
  - Pop occurs when o_tx_valid && i_tx_ready.
  - o_tx_data is the head word. It is held stable while o_tx_valid=1 and i_tx_ready=0.
  - Push when full:
    - With no pop in the same cycle: the word is dropped and overflow is set.
    - With a pop in the same cycle: the push is accepted and the count stays FIFO_DEPTH.
  - Push and pop in the same cycle at count 1..DEPTH-1: count unchanged, order preserved.
  - Push when empty: o_tx_valid rises the next cycle. There is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
  - A STATUS read returns the count before that cycle's push or pop.
- o_halt: sticky until reset. It does not gate the CPU or the counter; the system uses it to stop simulation.
- Reset mid-operation: asserting rst at any time immediately empties the FIFO, drops o_tx_valid and clears the flags. Pending pushes are lost.

Test Plan:
- RAM: write 0x1234 @200, then read @200 -> 0x1234 exactly 1 cycle after the address. Write 0x5555 @201 while reading @201 in the same cycle -> old value returned.
- FIFO order: push 1,2,3 with i_tx_ready=0 -> STATUS=0x0003. Raise i_tx_ready -> o_tx_data 1,2,3 on consecutive cycles, then o_tx_valid=0 and STATUS=0x0000.
- Overflow: push 9 words with ready=0 -> STATUS=0x8008 and the 9th word is lost. Write STATUS -> 0x0008. Push while full with ready=1 -> accepted, count stays 8.
- Counter: release reset, then read CYCLES after 100 cycles -> expected count ±0 per bench alignment. Write CYCLES -> the next read is 1. Force the counter to 0xFFFF -> the next value is 0x0000.
- Halt: write 0 to HALT -> o_halt=0. Write 0x0007 -> o_halt=1 and STATUS[14]=1. It stays set until rst is pulsed low.
- Async reset: assert rst low mid-drain with 4 words queued -> o_tx_valid=0 and o_ram_data_out=0 immediately. After deassert, STATUS=0x0000 and RAM data is retained.
